// File: rtl/pool_window_scheduler_if.sv
// Buffer read port and pooled-result stream
// for the pooling window scheduler.
interface pool_window_scheduler_if #(
  parameter int DW = 13,
  parameter int AW = 8,
  parameter int IW = 6
);
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic signed [DW-1:0] out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/pool_window_scheduler.sv
// 2x2/stride-2 max-pool + optional ReLU sequencer
// over a W x W feature map in a 1-cycle-latency buffer.
module pool_window_scheduler #(
  parameter int W    = 12,
  parameter int DW   = 13,
  parameter int AW   = 8,
  parameter int IW   = 6,
  parameter int RELU = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  pool_window_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    EMIT,
    DONE
  } state_t;

  localparam logic [IW-1:0] HALF    = IW'(W / 2);
  localparam logic [IW-1:0] HALF_M1 = IW'(W / 2 - 1);

  state_t               state;
  state_t               state_n;
  logic [1:0]           k;
  logic [IW-1:0]        r;
  logic [IW-1:0]        c;
  logic signed [DW-1:0] acc;
  logic signed [DW-1:0] peak;
  logic [AW-1:0]        base;
  logic [AW-1:0]        off;
  logic                 last_win;
  logic                 xfer;

  assign last_win = (r == HALF_M1) && (c == HALF_M1);
  assign xfer     = (state == EMIT) && bus.out_ready;

  assign base = AW'({r, 1'b0}) * AW'(W)
              + AW'({c, 1'b0});

  always_comb begin
    off = '0;
    unique case (k)
      2'd0: off = '0;
      2'd1: off = AW'(1);
      2'd2: off = AW'(W);
      2'd3: off = AW'(W + 1);
      default: off = '0;
    endcase
  end

  // Data for read k arrives while k+1 is issued,
  // so the last sample lands during WAIT.
  assign peak = (acc > bus.rd_data) ? acc : bus.rd_data;

  assign bus.rd_en     = (state == RD);
  assign bus.rd_addr   = (state == RD) ? base + off : '0;
  assign bus.out_valid = (state == EMIT);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RD;
      RD:   if (k == 2'd3) state_n = WAIT;
      WAIT: state_n = EMIT;
      EMIT: begin
        if (bus.out_ready) begin
          state_n = last_win ? DONE : RD;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      k            <= '0;
      r            <= '0;
      c            <= '0;
      acc          <= '0;
      bus.out_data <= '0;
      bus.out_idx  <= '0;
    end else begin
      if (state == RD) begin
        k <= k + 2'd1;
        if (k == 2'd1) begin
          acc <= bus.rd_data;
        end else if (k != 2'd0) begin
          acc <= peak;
        end
      end
      if (state == WAIT) begin
        if (RELU != 0 && peak[DW-1]) begin
          bus.out_data <= '0;
        end else begin
          bus.out_data <= peak;
        end
        bus.out_idx <= r * HALF + c;
      end
      if (xfer && !last_win) begin
        if (c == HALF_M1) begin
          c <= '0;
          r <= r + IW'(1);
        end else begin
          c <= c + IW'(1);
        end
      end
      if (state == DONE) begin
        r <= '0;
        c <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Bench for pool_window_scheduler: ramp, vector table,
// backpressure, start/reset abuse and random ready.
module tb_pool_window_scheduler;
  localparam int W  = 12;
  localparam int DW = 13;
  localparam int AW = 8;
  localparam int IW = 6;
  localparam int H  = W / 2;
  localparam int NW = H * H;

  typedef struct {
    int s[4];
    int e1;
    int e0;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic busy1, done1, busy0, done0;

  always #5 clk = ~clk;

  pool_window_scheduler_if #(.DW(DW), .AW(AW), .IW(IW)) b1 ();
  pool_window_scheduler_if #(.DW(DW), .AW(AW), .IW(IW)) b0 ();

  pool_window_scheduler #(
    .W(W), .DW(DW), .AW(AW), .IW(IW), .RELU(1)
  ) u1 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy1), .done(done1), .bus(b1.master)
  );

  pool_window_scheduler #(
    .W(W), .DW(DW), .AW(AW), .IW(IW), .RELU(0)
  ) u0 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy0), .done(done0), .bus(b0.master)
  );

  assign b1.out_ready = ready;
  assign b0.out_ready = ready;

  logic signed [DW-1:0] mem [W*W];

  // Junk on non-read cycles exposes wrong capture timing.
  always @(posedge clk) begin
    b1.rd_data <= b1.rd_en ? mem[b1.rd_addr] : DW'($urandom);
    b0.rd_data <= b0.rd_en ? mem[b0.rd_addr] : DW'($urandom);
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ndone = 0;
  int q_idx1[$], q_dat1[$], q_idx0[$], q_dat0[$], q_addr[$];
  bit prev_hold = 0;
  bit prev_rst = 0;
  int prev_idx = 0;
  int prev_dat = 0;
  vec_t tbl[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int model(input int w, input bit relu);
    int r, c, b, m;
    int o[4];
    r = w / H;
    c = w % H;
    b = 2 * r * W + 2 * c;
    o = '{0, 1, W, W + 1};
    m = int'(mem[b]);
    for (int j = 1; j < 4; j++)
      if (int'(mem[b + o[j]]) > m) m = int'(mem[b + o[j]]);
    if (relu && m < 0) m = 0;
    return m;
  endfunction

  function automatic int ramp_exp(input int w);
    return (2 * (w / H) + 1) * W + 2 * (w % H) + 1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rd_en_vs_valid", int'(b1.rd_en & b1.out_valid), 0);
      if (prev_hold && prev_rst) begin
        chk("hold_valid", int'(b1.out_valid), 1);
        chk("hold_idx", int'(b1.out_idx), prev_idx);
        chk("hold_data", int'(b1.out_data), prev_dat);
      end
      if (b1.rd_en) q_addr.push_back(int'(b1.rd_addr));
      if (b1.out_valid && ready) begin
        q_idx1.push_back(int'(b1.out_idx));
        q_dat1.push_back(int'(b1.out_data));
      end
      if (b0.out_valid && ready) begin
        q_idx0.push_back(int'(b0.out_idx));
        q_dat0.push_back(int'(b0.out_data));
      end
      if (done1) ndone++;
    end
    prev_hold = b1.out_valid && !ready;
    prev_rst  = rst;
    prev_idx  = int'(b1.out_idx);
    prev_dat  = int'(b1.out_data);
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, int'(b1.rd_en), 0);
    chk({tag, "_rd_addr"}, int'(b1.rd_addr), 0);
    chk({tag, "_out_data"}, int'(b1.out_data), 0);
    chk({tag, "_out_idx"}, int'(b1.out_idx), 0);
    chk({tag, "_out_valid"}, int'(b1.out_valid), 0);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
  endtask

  task automatic run_pass(input bit rnd, input bit abuse,
                          input int bp, input bit ramp,
                          input bit timing);
    int t0, dc, cnt, phase, e;
    bit got_done, ab_rd, ab_em;
    q_idx1.delete(); q_dat1.delete();
    q_idx0.delete(); q_dat0.delete();
    q_addr.delete();
    ndone = 0; got_done = 0; phase = 0; cnt = 0;
    ab_rd = 0; ab_em = 0; dc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4000 && !got_done; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (bp >= 0) begin
        if (phase == 0 && b1.out_valid &&
            b1.out_idx == IW'(bp - 1)) begin
          phase = 1;
        end else if (phase == 1) begin
          ready = 1'b0;
          if (b1.out_valid) begin
            cnt++;
            chk("bp_idx", int'(b1.out_idx), bp);
            chk("bp_data", int'(b1.out_data), model(bp, 1));
            chk("bp_rd_en", int'(b1.rd_en), 0);
            if (cnt > 10) begin
              ready = 1'b1;
              phase = 2;
            end
          end
        end else if (phase == 2) begin
          chk("bp_resume_rd", int'(b1.rd_en), 1);
          chk("bp_valid_drop", int'(b1.out_valid), 0);
          phase = 3;
        end
      end
      if (abuse) begin
        if (!ab_rd && b1.rd_en && cyc > t0 + 8) begin
          start = 1'b1;
          ab_rd = 1;
        end
        if (!ab_em && b1.out_valid) begin
          start = 1'b1;
          ab_em = 1;
        end
      end
      if (done1) begin
        got_done = 1;
        dc = cyc;
        if (abuse) start = 1'b1;
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b1;
    chk("busy_after_done", int'(busy1), 0);
    chk("done_one_cycle", int'(done1), 0);
    @(posedge clk); #1;
    chk("no_restart", int'(busy1), 0);
    chk("n_out_relu1", q_idx1.size(), NW);
    chk("n_out_relu0", q_idx0.size(), NW);
    for (int i = 0; i < NW && i < q_idx1.size(); i++) begin
      e = ramp ? ramp_exp(i) : model(i, 1);
      chk("idx_relu1", q_idx1[i], i);
      chk("data_relu1", q_dat1[i], e);
    end
    for (int i = 0; i < NW && i < q_idx0.size(); i++) begin
      e = ramp ? ramp_exp(i) : model(i, 0);
      chk("idx_relu0", q_idx0[i], i);
      chk("data_relu0", q_dat0[i], e);
    end
    chk("done_count", ndone, 1);
    chk("n_reads", q_addr.size(), 4 * NW);
    if (q_addr.size() == 4 * NW) begin
      chk("addr_first0", q_addr[0], 0);
      chk("addr_first1", q_addr[1], 1);
      chk("addr_first2", q_addr[2], W);
      chk("addr_first3", q_addr[3], W + 1);
      chk("addr_last0", q_addr[4*NW-4], 130);
      chk("addr_last1", q_addr[4*NW-3], 131);
      chk("addr_last2", q_addr[4*NW-2], 142);
      chk("addr_last3", q_addr[4*NW-1], 143);
    end
    if (timing) chk("done_latency", dc - t0, 6 * NW + 1);
    if (bp >= 0) chk("bp_hold_cycles", cnt, 11);
  endtask

  task automatic fill_random();
    for (int i = 0; i < W * W; i++) mem[i] = DW'($urandom);
  endtask

  initial begin
    int b, w;
    tbl[0].s = '{-5, -1, -9, -4096};     tbl[0].e1 = 0;    tbl[0].e0 = -1;
    tbl[1].s = '{4095, -4096, 0, 1};     tbl[1].e1 = 4095; tbl[1].e0 = 4095;
    tbl[2].s = '{-4096, -4096, -4096, -4096};
    tbl[2].e1 = 0;    tbl[2].e0 = -4096;
    tbl[3].s = '{0, 0, 0, 0};            tbl[3].e1 = 0;    tbl[3].e0 = 0;
    tbl[4].s = '{-1, -2, -3, 7};         tbl[4].e1 = 7;    tbl[4].e0 = 7;
    tbl[5].s = '{-4095, -4096, -4094, -4093};
    tbl[5].e1 = 0;    tbl[5].e0 = -4093;
    tbl[6].s = '{100, -100, 200, -300};  tbl[6].e1 = 200;  tbl[6].e0 = 200;

    for (int i = 0; i < W * W; i++) mem[i] = DW'(i);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    run_pass(0, 0, -1, 1, 1);

    fill_random();
    for (int j = 0; j < 7; j++) begin
      w = j * 5;
      b = 2 * (w / H) * W + 2 * (w % H);
      mem[b]         = DW'(tbl[j].s[0]);
      mem[b + 1]     = DW'(tbl[j].s[1]);
      mem[b + W]     = DW'(tbl[j].s[2]);
      mem[b + W + 1] = DW'(tbl[j].s[3]);
    end
    run_pass(0, 1, -1, 0, 1);
    for (int j = 0; j < 7; j++) begin
      if (q_dat1.size() > j * 5) chk("vec_relu1", q_dat1[j*5], tbl[j].e1);
      if (q_dat0.size() > j * 5) chk("vec_relu0", q_dat0[j*5], tbl[j].e0);
    end

    fill_random();
    run_pass(0, 0, 2, 0, 0);

    ndone = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_idle", int'(busy1), 0);
    chk("midreset_no_done", ndone, 0);

    fill_random();
    run_pass(1, 0, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_window_scheduler.md
# pool_window_scheduler

Controller that sequences 2x2/stride-2 max-pooling plus ReLU over one convolution feature map held in a synchronous-read buffer. Sits between a conv layer's feature-map store and the next layer or output stage. It walks the pooling windows in row-major order, issues the four buffer reads per window and reduces them to a signed maximum. It then clamps the result and hands it downstream on a valid/ready handshake, replacing fixed-cadence pooling loops with a backpressure-aware sequencer.

## Interface
- W, 12: feature-map side (N-M+1); even, >= 2
- DW, 13: signed sample width
- AW, 8: buffer address width; 2^AW >= W*W
- IW, 6: output index width; 2^IW >= (W/2)^2
- RELU, 1: 1 = clamp negative maxima to 0; 0 = pass through
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- start  in  1  begin one feature-map pass; sampled only in IDLE
- rd_en  out  1  buffer read strobe
- rd_addr  out  AW  buffer read address, row-major (row*W+col)
- rd_data  in  DW signed  buffer data, valid exactly 1 cycle after rd_en
- out_data  out  DW signed  pooled and ReLU'd result
- out_idx  out  IW  pooled element index, 0..(W/2)^2-1, row-major
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final transfer

## Operation
- States: IDLE, RD, WAIT, EMIT, DONE.
- IDLE: start=1 -> RD; window r=c=0, read counter k=0.
- RD (4 cycles, k=0..3): rd_en=1, rd_addr = base, base+1, base+W, base+W+1, with base = 2r*W + 2c. After k=3 -> WAIT.
- Reduction:
  - rd_data returned for k=0 loads the accumulator directly; it is never initialised to 0 or to min.
  - k=1..3: acc = signed max(acc, rd_data).
- WAIT: rd_en=0. Captures the 4th sample, then registers out_data = (RELU && acc<0) ? 0 : acc and out_idx = r*(W/2)+c. -> EMIT.
- EMIT: out_valid=1.
  - Transfer when out_valid && out_ready.
  - On transfer, if the window was the last one -> DONE; otherwise advance c (wrap to 0 and increment r at c=W/2-1) -> RD.
  - No transfer: hold state, out_data and out_idx stable, rd_en=0.
- DONE: done=1 for one cycle -> IDLE.
- start outside IDLE (including the DONE cycle) is ignored.
- Arithmetic: signed two's-complement compare at DW bits; no widening, no saturation.

## Timing
- Reset (rst=0 at an edge): state IDLE. rd_en=0, rd_addr=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0, all counters 0. This takes effect at the next edge from any state.
- Reset mid-pass: the pass is abandoned, no done pulse is emitted, and a pending out_valid drops. The next start restarts at out_idx 0.
- start high at cycle t (IDLE):
  - RD during t+1..t+4.
  - Data returns t+2..t+5.
  - WAIT at t+5.
  - First out_valid at t+6.
- With out_ready tied high, each window takes 6 cycles (4 RD, WAIT, EMIT). The final EMIT is at t+6*(W/2)^2 and done at the cycle after it.
- out_valid rises only on entry to EMIT and falls only on the cycle after a transfer.
- rd_en is never high while out_valid is high.

## Test plan
- W=4, buffer = ramp 0..15, RELU=1, out_ready=1. Expect:
  - outputs (idx,data) = (0,5), (1,7), (2,13), (3,15);
  - first window rd_addr 0,1,4,5;
  - done exactly one cycle after the idx-3 transfer, busy low the cycle after that.
- Sign handling, window {-5,-1,-9,-4096}: RELU=1 -> 0; RELU=0 -> -1. A window of {4095,-4096,0,1} -> 4095.
- Backpressure: hold out_ready=0 for 10 cycles at idx 2. Expect out_valid held, out_data/out_idx stable, rd_en=0 throughout. Raising out_ready gives one transfer, then RD resumes next cycle.
- Protocol abuse:
  - start pulsed during RD, EMIT and DONE -> no restart, no idx perturbation.
  - rst=0 during the second RD cycle -> all outputs at reset values next cycle, no done; new start -> idx 0 and rd_addr 0 first.
- Default W=12, random signed buffer, out_ready=1. Expect:
  - 36 outputs matching a reference model;
  - first window addresses 0,1,12,13; last window 130,131,142,143;
  - start at t gives done at t+217.
- Random out_ready (50%) over a full W=12 pass. Expect the same 36 results in order, no dropped or duplicated idx, and exactly one done.
